// File: rtl/fifo8x16.sv
// fifo8x16: 8-entry x 16-bit first-word-fall-through FIFO with valid/ready on both sides
module DMux8Way (
    input  logic       in,
    input  logic [2:0] sel,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       h
);
    assign {h, g, f, e, d, c, b, a} = 8'(in) << sel;
endmodule

module Mux8Way16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [15:0] e,
    input  logic [15:0] f,
    input  logic [15:0] g,
    input  logic [15:0] h,
    input  logic [2:0]  sel,
    output logic [15:0] out
);
    assign out = sel[2] ? (sel[1] ? (sel[0] ? h : g) : (sel[0] ? f : e))
                        : (sel[1] ? (sel[0] ? d : c) : (sel[0] ? b : a));
endmodule

module fifo8x16 #(
    parameter int DEPTH       = 8,
    parameter int AFULL_LEVEL = 6
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  count,
    output logic        full,
    output logic        empty,
    output logic        almost_full
);
    logic [15:0] mem [8];
    logic [2:0]  wr_ptr;
    logic [2:0]  rd_ptr;
    logic [7:0]  we;
    logic [15:0] head;
    logic        push;
    logic        pop;

    // A word offered in the reset cycle must not land in storage either.
    assign push        = in_valid && in_ready && reset_n;
    assign pop         = out_valid && out_ready;
    assign full        = count == 4'(DEPTH);
    assign empty       = count == 4'd0;
    assign almost_full = count >= 4'(AFULL_LEVEL);
    assign in_ready    = !full;
    assign out_valid   = !empty;
    assign out         = empty ? 16'h0000 : head;

    DMux8Way u_dmux (
        .in(push), .sel(wr_ptr),
        .a(we[0]), .b(we[1]), .c(we[2]), .d(we[3]),
        .e(we[4]), .f(we[5]), .g(we[6]), .h(we[7])
    );

    Mux8Way16 u_mux (
        .a(mem[0]), .b(mem[1]), .c(mem[2]), .d(mem[3]),
        .e(mem[4]), .f(mem[5]), .g(mem[6]), .h(mem[7]),
        .sel(rd_ptr), .out(head)
    );

    // Storage: only the entry strobed by the decoded write pointer loads.
    always_ff @(posedge clock) begin
        for (int k = 0; k < 8; k++)
            if (we[k]) mem[k] <= in;
    end

    // Pointers wrap naturally at 8; count moves only on an unbalanced push/pop.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= 3'd0;
            rd_ptr <= 3'd0;
            count  <= 4'd0;
        end else begin
            wr_ptr <= wr_ptr + 3'(push);
            rd_ptr <= rd_ptr + 3'(pop);
            count  <= count + 4'(push) - 4'(pop);
        end
    end
endmodule

// File: tb/tb_fifo8x16.sv
// tb_fifo8x16: directed and random stimulus checked against a queue-based FIFO model
module tb_fifo8x16;
    logic        clock;
    logic        reset_n;
    logic [15:0] in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        almost_full;

    int checks   = 0;
    int failures = 0;
    logic [15:0] q[$];

    fifo8x16 dut (
        .clock(clock), .reset_n(reset_n),
        .in(in), .in_valid(in_valid), .in_ready(in_ready),
        .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .full(full), .empty(empty), .almost_full(almost_full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int n = q.size();
        chk("count", 16'(count), 16'(n));
        chk("empty", 16'(empty), 16'(n == 0));
        chk("full", 16'(full), 16'(n == 8));
        chk("almost_full", 16'(almost_full), 16'(n >= 6));
        chk("in_ready", 16'(in_ready), 16'(n < 8));
        chk("out_valid", 16'(out_valid), 16'(n > 0));
        chk("out", out, n > 0 ? q[0] : 16'h0000);
    endtask

    // One clock: drive inputs, apply the model's view of the edge, check after it.
    task automatic tick(input logic v, input logic [15:0] d, input logic r, input logic rn);
        bit do_push, do_pop;
        in_valid  = v;
        in        = d;
        out_ready = r;
        reset_n   = rn;
        do_push = v && q.size() < 8;
        do_pop  = r && q.size() > 0;
        @(posedge clock);
        if (!rn) q.delete();
        else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(d);
        end
        @(negedge clock);
        check_all();
    endtask

    initial begin
        in_valid = 0; in = 0; out_ready = 0; reset_n = 0;
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);
        tick(1, 16'h1111, 0, 1);
        tick(0, 0, 1, 1);
        for (int i = 1; i <= 8; i++) tick(1, 16'(i), 0, 1);
        tick(1, 16'hDEAD, 0, 1);
        tick(1, 16'hDEAD, 0, 1);
        for (int i = 0; i < 8; i++) tick(0, 0, 1, 1);
        tick(0, 0, 1, 1);
        for (int i = 0; i < 20; i++) begin
            tick(1, 16'h0100 + 16'(i), 0, 1);
            tick(0, 0, 1, 1);
        end
        for (int i = 0; i < 3; i++) tick(1, 16'h0200 + 16'(i), 0, 1);
        for (int i = 3; i < 13; i++) tick(1, 16'h0200 + 16'(i), 1, 1);
        for (int i = 0; i < 3; i++) tick(0, 0, 1, 1);
        for (int i = 0; i < 5; i++) tick(1, 16'h0300 + 16'(i), 0, 1);
        tick(1, 16'h0399, 1, 0);
        tick(1, 16'hBEEF, 0, 1);
        tick(0, 0, 0, 1);
        tick(0, 0, 1, 1);
        for (int i = 0; i < 400; i++)
            tick(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 60) != 0));
        for (int i = 0; i < 400; i++)
            tick(1'($urandom_range(0, 2) == 0), 16'($urandom), 1'($urandom_range(0, 3) != 0), 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo8x16.md
Name: fifo8x16

Overview:
- 8-entry × 16-bit synchronous FIFO with a valid/ready handshake on both sides.
- Storage is eight 16-bit registers.
- The write strobe is decoded from the write pointer by the library DMux8Way.
- The read word is selected from the read pointer by the library Mux8Way16.
- It is the buffering stage downstream of the 8-way mux/demux primitives, and feeds CPU-side consumers.

Parameters:
- DEPTH, 8, number of entries. Fixed to match the 8-way decode and select; any other value is unsupported.
- AFULL_LEVEL, 6, count at or above which almost_full asserts. Legal range 1..8.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- in  input  16  write data.
- in_valid  input  1  producer has a word on in.
- in_ready  output  1  FIFO can accept a word this cycle.
- out  output  16  head-of-queue data.
- out_valid  output  1  out holds a valid word.
- out_ready  input  1  consumer takes out this cycle.
- count  output  4  number of stored words, 0..8.
- full  output  1  count == 8.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AFULL_LEVEL.

Behaviour:
- Reset: one clock is synchronous and active-low. When reset_n=0 at a rising edge:
  - wr_ptr, rd_ptr and count are cleared to 0.
  - Storage contents are not cleared.
- Outputs after reset: count=0, empty=1, full=0, almost_full=0, out_valid=0, in_ready=1, out=16'h0000.
- Reset mid-operation discards all queued words. A push or pop in the reset cycle has no effect.
- Push: occurs at a clock edge when in_valid && in_ready.
  - mem[wr_ptr] <= in.
  - wr_ptr <= wr_ptr+1, mod 8, so 7 wraps to 0.
  - The per-entry write enable is the DMux8Way output for in=push, sel=wr_ptr.
- Pop: occurs at a clock edge when out_valid && out_ready.
  - rd_ptr <= rd_ptr+1, mod 8.
- Count update:
  - count+1 on push only.
  - count-1 on pop only.
  - Unchanged on both or neither.
- Handshake outputs (combinational from registered state only):
  - in_ready = !full. Must not depend on out_ready, so there is no push-through when full.
  - out_valid = !empty.
- out is first-word fall-through:
  - out = Mux8Way16(mem, rd_ptr) when !empty.
  - out = 16'h0000 when empty.
  - A word written at edge N is visible on out after edge N when the FIFO was empty, so latency is 1 cycle.
- Simultaneous events:
  - Push and pop in the same cycle with 1..7 words: both take effect and count is unchanged.
  - When empty: no pop is possible, so only the push occurs.
  - When full: no push is possible, so only the pop occurs. in_ready rises the cycle after the pop.
- Protocol violations:
  - in_valid while !in_ready is ignored, with no corruption.
  - out_ready while !out_valid is ignored, with no pointer change.
- Data ordering: strict FIFO. Data is never reordered, duplicated or dropped across pointer wrap.
- Status flags are decoded from the count register. No glitch-sensitive logic feeds status flags.

Test Plan:
- Reset then idle, with reset_n held 0 for 2 cycles and then 1 → count=0, empty=1, out_valid=0, in_ready=1, out=16'h0000.
- Push 16'h1111 with out_ready=0 → next cycle out_valid=1, out=16'h1111, count=1. Assert out_ready for 1 cycle → empty=1, out=16'h0000.
- Fill 8 words 16'h0001..16'h0008 → after the 6th, almost_full=1. After the 8th, full=1 and in_ready=0. Offer 16'hDEAD with in_valid=1 → not stored, count stays 8. Drain 8 → out sequence is 0001..0008.
- Wrap: push/pop alternately 20 words 16'h0100+i → all 20 are read in order, and both pointers pass 7→0 twice with no loss.
- Steady state at count=3 with in_valid=out_ready=1 for 10 cycles using ascending data → count stays 3 every cycle and the output stays in order.
- Reset mid-operation at count=5 (pulse reset_n=0 for one edge with in_valid=1, out_ready=1) → count=0, empty=1. The next push of 16'hBEEF appears on out as the only word.
